// File: rtl/approx_mult_err_monitor.sv
// Exhaustive error-characterisation sweep around a WIDTHxWIDTH approximate multiplier.
// Drives every operand pair and compares each returned product against the exact
// product. It accumulates the error count, the summed error distance, the maximum
// error distance and the first pair that reached that maximum.
module approx_mult_err_monitor #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SUM_W = 4 * WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 pause,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    input  logic [2*WIDTH-1:0]   approx_p,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH:0]     err_count,
    output logic [SUM_W-1:0]     ed_sum,
    output logic [2*WIDTH-1:0]   ed_max,
    output logic [WIDTH-1:0]     worst_a,
    output logic [WIDTH-1:0]     worst_b
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [PW-1:0]    idx;

    // Stage 1: operands and returned product as seen by the multiplier.
    logic             v1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [PW-1:0]    p1;

    // Stage 2: error distance of the stage-1 entry, ready for accumulation.
    logic             v2;
    logic [WIDTH-1:0] a2;
    logic [WIDTH-1:0] b2;
    logic [PW-1:0]    ed2;

    logic             accept_c;
    logic             run_c;
    logic             last_c;
    logic [PW-1:0]    exact_c;
    logic [PW-1:0]    ed_c;

    // Operands come straight from the sweep index.
    assign op_a = idx[WIDTH-1:0];
    assign op_b = idx[PW-1:WIDTH];

    // Control qualifiers and unsigned error distance of the stage-1 entry.
    always_comb begin
        accept_c = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        run_c    = !pause && ((state_q == S_SWEEP) || (state_q == S_DRAIN));
        last_c   = (idx == {PW{1'b1}});
        exact_c  = PW'(a1) * PW'(b1);
        ed_c     = (exact_c >= p1) ? (exact_c - p1) : (p1 - exact_c);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the sweep ends once the last entry has left stage 2.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_SWEEP;
            end
            S_SWEEP: begin
                if (!pause && last_c) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!pause && !v1) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sweep index, pipeline stages, accumulators and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            v1        <= 1'b0;
            a1        <= '0;
            b1        <= '0;
            p1        <= '0;
            v2        <= 1'b0;
            a2        <= '0;
            b2        <= '0;
            ed2       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            ed_sum    <= '0;
            ed_max    <= '0;
            worst_a   <= '0;
            worst_b   <= '0;
        end else if (accept_c) begin
            idx       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err_count <= '0;
            ed_sum    <= '0;
            ed_max    <= '0;
            worst_a   <= '0;
            worst_b   <= '0;
        end else if (run_c) begin
            if (state_q == S_SWEEP) begin
                a1  <= op_a;
                b1  <= op_b;
                p1  <= approx_p;
                v1  <= 1'b1;
                idx <= idx + PW'(1);
            end else begin
                v1  <= 1'b0;
            end

            v2 <= v1;
            if (v1) begin
                a2  <= a1;
                b2  <= b1;
                ed2 <= ed_c;
            end

            if (v2) begin
                err_count <= err_count + CW'(ed2 != '0);
                ed_sum    <= ed_sum + SUM_W'(ed2);
                // Strictly greater so that ties keep the earliest pair.
                if (ed2 > ed_max) begin
                    ed_max  <= ed2;
                    worst_a <= a2;
                    worst_b <= b2;
                end
            end

            if ((state_q == S_DRAIN) && !v1) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Self-checking bench for approx_mult_err_monitor. It uses several multiplier
// stand-ins, random stalls, restarts and a mid-sweep reset, and it checks the DUT
// against an exhaustive reference model.
module tb_approx_mult_err_monitor;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned NPAIRS  = 256;
    localparam int unsigned LATENCY = NPAIRS + 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        pause;
    logic [3:0]  op_a;
    logic [3:0]  op_b;
    logic [7:0]  approx_p;
    logic        busy;
    logic        done;
    logic [8:0]  err_count;
    logic [15:0] ed_sum;
    logic [7:0]  ed_max;
    logic [3:0]  worst_a;
    logic [3:0]  worst_b;

    int          mode;
    logic [7:0]  rtab [NPAIRS];
    logic [7:0]  garbage;

    int          n_checks;
    int          n_errors;

    approx_mult_err_monitor #(.WIDTH(WIDTH), .SUM_W(4 * WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .op_a      (op_a),
        .op_b      (op_b),
        .approx_p  (approx_p),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .ed_sum    (ed_sum),
        .ed_max    (ed_max),
        .worst_a   (worst_a),
        .worst_b   (worst_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in selected by mode.
    function automatic logic [7:0] ref_p(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] ex;
        logic [7:0] i;
        ex = 8'(a) * 8'(b);
        i  = {b, a};
        case (mode)
            0:       return ex;
            1:       return 8'h00;
            2:       return ex ^ 8'h01;
            3:       return {ex[7:2], a[1:0] | b[1:0]};
            default: return rtab[i];
        endcase
    endfunction

    // The DUT ignores the product while stalled, so junk is driven in that case.
    always_comb begin
        approx_p = pause ? garbage : ref_p(op_a, op_b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Exhaustive reference: walk every pair in sweep order, using plain arithmetic.
    task automatic check_results(input string tag);
        int cnt, sum, mx, wa, wb;
        cnt = 0; sum = 0; mx = 0; wa = 0; wb = 0;
        for (int i = 0; i < int'(NPAIRS); i++) begin
            int a, b, ex, p, ed;
            a  = i % 16;
            b  = i / 16;
            ex = a * b;
            p  = int'(ref_p(4'(a), 4'(b)));
            ed = (ex > p) ? ex - p : p - ex;
            if (ed != 0) cnt++;
            sum += ed;
            if (ed > mx) begin
                mx = ed; wa = a; wb = b;
            end
        end
        check({tag, "_err_count"}, 32'(err_count), 32'(cnt));
        check({tag, "_ed_sum"},    32'(ed_sum),    32'(sum));
        check({tag, "_ed_max"},    32'(ed_max),    32'(mx));
        check({tag, "_worst_a"},   32'(worst_a),   32'(wa));
        check({tag, "_worst_b"},   32'(worst_b),   32'(wb));
        check({tag, "_busy_low"},  32'(busy),      32'd0);
    endtask

    // Pulse start and count edges until done. Optionally stall randomly or re-pulse start mid-sweep.
    task automatic run_sweep(input string tag, input int pause_pct, input int restart_at,
                             output int edges, output int paused);
        edges  = 0;
        paused = 0;
        @(negedge clk);
        start = 1'b1;
        pause = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        check({tag, "_done_cleared"},     32'(done), 32'd0);
        check({tag, "_err_cleared"},      32'(err_count), 32'd0);
        while (edges < 3000) begin
            @(negedge clk);
            start   = (restart_at >= 0) && ({op_b, op_a} == 8'(restart_at));
            pause   = ($urandom_range(99) < 32'(pause_pct));
            garbage = 8'($urandom);
            @(posedge clk);
            edges++;
            if (pause) paused++;
            #1;
            if (done) break;
        end
        @(negedge clk);
        start = 1'b0;
        pause = 1'b0;
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    int edges;
    int paused;
    int wait_cnt;

    initial begin
        n_checks = 0;
        n_errors = 0;
        mode     = 0;
        garbage  = 8'h00;
        start    = 1'b0;
        pause    = 1'b0;
        rst_n    = 1'b0;
        for (int i = 0; i < int'(NPAIRS); i++) rtab[i] = 8'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_done",   32'(done),      32'd0);
        check("rst_op",     32'({op_b, op_a}), 32'd0);
        check("rst_errcnt", 32'(err_count), 32'd0);
        check("rst_edmax",  32'(ed_max),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pause outside a sweep does nothing.
        @(negedge clk); pause = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_pause_busy", 32'(busy), 32'd0);
        @(negedge clk); pause = 1'b0;

        // Fixed-response stand-ins without stalls, each restarted from DONE.
        for (int m = 0; m < 4; m++) begin
            string tag;
            mode = m;
            tag  = $sformatf("mode%0d", m);
            run_sweep(tag, 0, -1, edges, paused);
            check({tag, "_latency"}, 32'(edges), 32'(LATENCY));
            check_results(tag);
        end

        // Approximate multiplier with random stalls: same results, latency grows by the stall count.
        mode = 3;
        run_sweep("approx_stall", 30, -1, edges, paused);
        check("approx_stall_latency", 32'(edges), 32'(LATENCY + paused));
        check_results("approx_stall");

        // Random product table with heavy stalls.
        mode = 4;
        run_sweep("rand_stall", 50, -1, edges, paused);
        check("rand_stall_latency", 32'(edges), 32'(LATENCY + paused));
        check_results("rand_stall");

        // Pause held in DONE leaves the results and done untouched.
        @(negedge clk); pause = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("done_pause_done", 32'(done), 32'd1);
        @(negedge clk); pause = 1'b0;
        check_results("done_pause");

        // A start pulse in mid-sweep is ignored.
        run_sweep("restart100", 0, 100, edges, paused);
        check("restart100_latency", 32'(edges), 32'(LATENCY));
        check_results("restart100");

        // Asynchronous reset mid-sweep, then a clean rerun.
        mode = 2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_cnt = 0;
        while (({op_b, op_a} != 8'd37) && (wait_cnt < 1000)) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("reach_idx37", 32'({op_b, op_a}), 32'd37);
        check("pre_reset_errs", 32'(err_count > 0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_op",     32'({op_b, op_a}), 32'd0);
        check("arst_busy",   32'(busy),      32'd0);
        check("arst_errcnt", 32'(err_count), 32'd0);
        check("arst_edsum",  32'(ed_sum),    32'd0);
        check("arst_edmax",  32'(ed_max),    32'd0);
        check("arst_worst",  32'({worst_b, worst_a}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep("after_rst", 0, -1, edges, paused);
        check("after_rst_latency", 32'(edges), 32'(LATENCY));
        check_results("after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/approx_mult_err_monitor.md
Name: approx_mult_err_monitor

Overview:
Exhaustive error-characterisation stage that sits around the 4x4 approximate multiplier. It drives every operand pair into the multiplier's A/B inputs and consumes the product the multiplier returns. It compares each returned product against the exact product and accumulates four figures: error count, summed absolute error distance, maximum error distance, and the first operand pair that reached the maximum. Results feed the team's error-rate/MED reporting flow for each multiplier variant.

Parameters:
WIDTH, 4, operand width; the product is 2*WIDTH bits and the sweep is 2^(2*WIDTH) pairs
SUM_W, 4*WIDTH, width of the error-distance accumulator; large enough that it cannot overflow over a full sweep

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a sweep; honoured only in IDLE or DONE
pause  input  1  high freezes the sweep index and pipeline (stall)
op_a  output  WIDTH  operand driven to multiplier A
op_b  output  WIDTH  operand driven to multiplier B
approx_p  input  2*WIDTH  product returned combinationally by the multiplier for the current op_a/op_b
busy  output  1  high from the accepted start until done rises
done  output  1  high in DONE; held until the next accepted start
err_count  output  2*WIDTH+1  number of pairs with approx_p != exact
ed_sum  output  SUM_W  sum of |exact - approx_p| over all pairs
ed_max  output  2*WIDTH  largest |exact - approx_p|
worst_a  output  WIDTH  op_a of the first pair reaching ed_max
worst_b  output  WIDTH  op_b of the first pair reaching ed_max

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; idx=0; op_a=op_b=0; busy=0; done=0; all accumulators, worst_a and worst_b = 0; pipeline valid bits = 0.
- Operand mapping: idx is a 2*WIDTH-bit counter. op_a=idx[WIDTH-1:0], op_b=idx[2*WIDTH-1:WIDTH]. op_a/op_b come directly from the idx register.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE or DONE, start=1: clear all accumulators, worst_a, worst_b, idx and done; go to SWEEP; busy=1 from the next cycle.
- SWEEP, pause=0, each edge:
  - capture stage-1 register {op_a, op_b, approx_p} with v1=1;
  - idx increments;
  - on the edge that captures idx=all-ones, idx wraps to 0 and the state goes to DRAIN.
- Stage 2, on an edge where v1=1 and pause=0:
  - exact = a*b at full 2*WIDTH width;
  - ed = |exact - approx_p|, computed unsigned without wrap;
  - err_count += (ed != 0); ed_sum += ed;
  - if ed > ed_max (strictly greater): update ed_max, worst_a and worst_b. Ties keep the earlier pair.
- DRAIN: the first edge with pause=0 retires the final stage-1 entry; the state goes to DONE; done=1, busy=0.
- Latency: with no pause, done rises 2^(2*WIDTH)+2 clock edges after the edge that samples start.
- pause=1: idx, v1, stage-1 and stage-2 contents and the state all hold. approx_p is ignored while paused. The multiplier sees the same operands, so the result is unchanged by stalls.
- start while in SWEEP or DRAIN is ignored, with no effect on counters.
- pause in IDLE or DONE has no effect.
- Reset mid-sweep: immediate return to the reset values. No partial results are retained.
- Outputs err_count, ed_sum, ed_max, worst_a and worst_b update live during the sweep. They are final only while done=1.

Test Plan:
- approx_p = exact product (ideal loopback) -> done after 258 cycles; err_count=0, ed_sum=0, ed_max=0, worst_a=worst_b=0.
- approx_p tied to 0 -> err_count=225, ed_sum=14400, ed_max=225, worst_a=15, worst_b=15.
- approx_p = exact XOR 8'h01 -> err_count=256, ed_sum=256, ed_max=1, worst_a=0, worst_b=0 (tie keeps first).
- Real 4x4 approximate multiplier connected -> results match a golden model's exhaustive err_count, ed_sum and ed_max; pause toggled randomly gives identical final values, and done is delayed exactly by the number of paused cycles.
- start pulsed again at idx=100 -> ignored; final values equal the uninterrupted run. start in DONE -> accumulators clear and the sweep repeats.
- rst_n low at idx=37 -> asynchronously all outputs 0, state IDLE; after a subsequent start the results equal a clean run.
